lsb_queue_param: RTL and testbench

//  Parametrised in-order load/store queue between dispatch, the LSB reservation station, the ROB and the memory controller.

---
 rtl/lsb_queue_param_pkg.sv | 44 ++++
 rtl/lsb_queue_param_if.sv | 25 ++
 rtl/lsb_queue_param_load_ext.sv | 27 ++
 rtl/lsb_queue_param.sv | 220 ++++++++++++++++++++++
 tb/tb_lsb_queue_param.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsb_queue_param_pkg.sv
// Shared types and helpers for the load/store queue: entry lifecycle states,
// funct3 encodings, memory access size codes and small decode functions.
package lsb_queue_param_pkg;

    // Lifecycle of one queue slot
    typedef enum logic [2:0] {
        ST_FREE        = 3'd0,
        ST_WAIT_OPND   = 3'd1,
        ST_WAIT_COMMIT = 3'd2,
        ST_READY       = 3'd3,
        ST_ISSUED      = 3'd4
    } entry_state_t;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size as seen by the memory controller
    typedef logic [1:0] work_type_t;
    localparam work_type_t WT_BYTE = 2'b00;
    localparam work_type_t WT_HALF = 2'b01;
    localparam work_type_t WT_WORD = 2'b11;

    // Size field of funct3 -> controller access size
    function automatic work_type_t op_work_type(input logic [1:0] size);
        case (size)
            2'b00:   return WT_BYTE;
            2'b01:   return WT_HALF;
            default: return WT_WORD;
        endcase
    endfunction

    // Loads without the 'unsigned' bit sign-extend their result
    function automatic logic load_sign_ext(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/lsb_queue_param_if.sv
// Request/response bundle between the load/store queue and the memory controller.
interface lsb_queue_param_if #(
    parameter int XLEN = 32
) ();
    import lsb_queue_param_pkg::*;

    logic             lsb_mem_ready;  // one-cycle request pulse
    logic             r_nw_in;        // 1 = write
    work_type_t       work_type;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data_in;        // store data, already sized
    logic             mem_busy;
    logic             mem_done;
    logic [XLEN-1:0]  data_out;       // load data, low-aligned

    modport master (
        output lsb_mem_ready, r_nw_in, work_type, addr, data_in,
        input  mem_busy, mem_done, data_out
    );

    modport slave (
        input  lsb_mem_ready, r_nw_in, work_type, addr, data_in,
        output mem_busy, mem_done, data_out
    );
endinterface

// File: rtl/lsb_queue_param_load_ext.sv
// Sizes a raw low-aligned load word according to funct3 (sign or zero extension).
module lsb_queue_param_load_ext
    import lsb_queue_param_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_value
);
    logic w_fill_b;
    logic w_fill_h;

    assign w_fill_b = load_sign_ext(i_op) & i_data[7];
    assign w_fill_h = load_sign_ext(i_op) & i_data[15];

    // Select the extension for the load width
    always_comb begin
        o_value = i_data;
        case (i_op)
            F3_LB, F3_LBU: o_value = {{(XLEN-8){w_fill_b}}, i_data[7:0]};
            F3_LH, F3_LHU: o_value = {{(XLEN-16){w_fill_h}}, i_data[15:0]};
            F3_LW:         o_value = i_data;
            default:       o_value = i_data;
        endcase
    end
endmodule

// File: rtl/lsb_queue_param.sv
// In-order load/store queue. Entries are allocated at the tail, receive their
// operands through a rob-id CAM, stores additionally wait for ROB commit, and
// the head entry is sent to memory one access at a time. A flush keeps only
// committed stores, which always sit contiguously at the head.
module lsb_queue_param
    import lsb_queue_param_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int ROB_W = 5,
    parameter int XLEN  = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                i_clear,
    input  logic                i_ls_ready,
    input  logic                i_ls_store,
    input  logic [2:0]          i_ls_op,
    input  logic [ROB_W-1:0]    i_ls_rob_id,
    output logic                o_ls_full,
    input  logic                i_lsb_rs_ready,
    input  logic [ROB_W-1:0]    i_lsb_rs_rob_id,
    input  logic [XLEN-1:0]     i_lsb_rs_st_value,
    input  logic [XLEN-1:0]     i_lsb_rs_ptr_value,
    input  logic                i_lsb_store_commit,
    input  logic [ROB_W-1:0]    i_lsb_store_commit_rob_id,
    lsb_queue_param_if.master   mem_if,
    output logic                o_lsb_cdb_ready,
    output logic [ROB_W-1:0]    o_lsb_cdb_rob_id,
    output logic [XLEN-1:0]     o_lsb_cdb_value
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage
    entry_state_t       r_state   [DEPTH];
    logic [2:0]         r_op      [DEPTH];
    logic [ROB_W-1:0]   r_rob_id  [DEPTH];
    logic [XLEN-1:0]    r_addr    [DEPTH];
    logic [XLEN-1:0]    r_value   [DEPTH];
    logic [DEPTH-1:0]   r_store;
    logic [DEPTH-1:0]   r_commit_seen;

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_kill;
    logic               r_outpend;

    logic               w_full;
    logic               w_clear;
    logic               w_upd;
    logic               w_done;
    logic               w_pop;
    logic               w_alloc;
    logic               w_issue;
    logic [PTR_W-1:0]   w_head_next;
    logic               w_head_ld_issued;
    logic [CNT_W-1:0]   w_n_keep;
    logic [XLEN-1:0]    w_st_mask [DEPTH];
    logic [XLEN-1:0]    w_ext_value;

    logic [DEPTH-1:0]   w_opnd_hit;
    logic [DEPTH-1:0]   w_commit_hit;
    logic [DEPTH-1:0]   w_alloc_hit;
    logic [DEPTH-1:0]   w_pop_hit;
    logic [DEPTH-1:0]   w_issue_hit;
    logic [DEPTH-1:0]   w_keep;

    assign w_full  = (r_count == FULL_CNT);
    assign w_clear = rdy_in & i_clear;
    // Flush overrides alloc, operand capture and commit
    assign w_upd   = rdy_in & ~i_clear;
    assign w_done  = rdy_in & mem_if.mem_done & r_outpend;
    // A completion that arrives for a killed load is swallowed without a pop
    assign w_pop   = w_done & ~r_kill;
    assign w_alloc = w_upd & i_ls_ready & ~w_full;
    // Head after this cycle's pop; also the issue candidate, which gives the
    // zero-bubble handoff from a completing access to the next one
    assign w_head_next = r_head + PTR_W'(w_pop);
    // Issue is held off during a flush so a doomed load never leaves the queue
    assign w_issue = w_upd & (~r_outpend | w_done) & ~mem_if.mem_busy
                   & (r_state[w_head_next] == ST_READY);
    assign w_head_ld_issued = (r_state[r_head] == ST_ISSUED) & ~r_store[r_head];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_opnd_hit[gi]   = w_upd & i_lsb_rs_ready
                                    & (r_state[gi] == ST_WAIT_OPND)
                                    & (r_rob_id[gi] == i_lsb_rs_rob_id);
            assign w_commit_hit[gi] = w_upd & i_lsb_store_commit & r_store[gi]
                                    & ((r_state[gi] == ST_WAIT_OPND) | (r_state[gi] == ST_WAIT_COMMIT))
                                    & (r_rob_id[gi] == i_lsb_store_commit_rob_id);
            assign w_alloc_hit[gi]  = w_alloc & (r_tail == PTR_W'(gi));
            assign w_pop_hit[gi]    = w_pop & (r_head == PTR_W'(gi));
            assign w_issue_hit[gi]  = w_issue & (w_head_next == PTR_W'(gi));
            // Committed stores survive a flush unless they retire this very cycle
            assign w_keep[gi]       = r_store[gi] & ~w_pop_hit[gi]
                                    & ((r_state[gi] == ST_READY) | (r_state[gi] == ST_ISSUED));
        end
    endgenerate

    // Store data sized by each entry's own funct3, ready for capture
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_st_mask[i] = i_lsb_rs_st_value;
            case (r_op[i])
                F3_SB:   w_st_mask[i] = {{(XLEN-8){1'b0}}, i_lsb_rs_st_value[7:0]};
                F3_SH:   w_st_mask[i] = {{(XLEN-16){1'b0}}, i_lsb_rs_st_value[15:0]};
                F3_SW:   w_st_mask[i] = i_lsb_rs_st_value;
                default: w_st_mask[i] = i_lsb_rs_st_value;
            endcase
        end
    end

    // Number of entries that stay in the queue across a flush
    always_comb begin
        w_n_keep = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_n_keep = w_n_keep + CNT_W'(w_keep[i]);
        end
    end

    // Per-entry lifecycle plus head/tail/count and outstanding-access tracking
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_kill        <= 1'b0;
            r_outpend     <= 1'b0;
            r_store       <= '0;
            r_commit_seen <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]  <= ST_FREE;
                r_op[i]     <= '0;
                r_rob_id[i] <= '0;
                r_addr[i]   <= '0;
                r_value[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_clear) begin
                    if (!w_keep[i]) begin
                        r_state[i]       <= ST_FREE;
                        r_commit_seen[i] <= 1'b0;
                    end
                end else begin
                    if (w_pop_hit[i])
                        r_state[i] <= ST_FREE;
                    if (w_issue_hit[i])
                        r_state[i] <= ST_ISSUED;
                    if (w_opnd_hit[i]) begin
                        r_addr[i]        <= i_lsb_rs_ptr_value;
                        r_value[i]       <= w_st_mask[i];
                        r_commit_seen[i] <= 1'b0;
                        if (!r_store[i] || w_commit_hit[i] || r_commit_seen[i])
                            r_state[i] <= ST_READY;
                        else
                            r_state[i] <= ST_WAIT_COMMIT;
                    end else if (w_commit_hit[i]) begin
                        // Early commit on a store still missing operands is remembered
                        if (r_state[i] == ST_WAIT_COMMIT)
                            r_state[i] <= ST_READY;
                        else
                            r_commit_seen[i] <= 1'b1;
                    end
                    if (w_alloc_hit[i]) begin
                        r_state[i]       <= ST_WAIT_OPND;
                        r_store[i]       <= i_ls_store;
                        r_op[i]          <= i_ls_op;
                        r_rob_id[i]      <= i_ls_rob_id;
                        r_commit_seen[i] <= 1'b0;
                    end
                end
            end

            r_head <= w_head_next;
            if (w_clear) begin
                r_tail  <= w_head_next + w_n_keep[PTR_W-1:0];
                r_count <= w_n_keep;
            end else begin
                r_tail  <= r_tail + PTR_W'(w_alloc);
                r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
            end

            if (w_issue)
                r_outpend <= 1'b1;
            else if (w_done)
                r_outpend <= 1'b0;

            if (w_done)
                r_kill <= 1'b0;
            else if (w_clear && w_head_ld_issued)
                r_kill <= 1'b1;
        end
    end

    lsb_queue_param_load_ext #(.XLEN(XLEN)) u_load_ext (
        .i_op    (r_op[r_head]),
        .i_data  (mem_if.data_out),
        .o_value (w_ext_value)
    );

    assign o_ls_full = w_full;

    // Request fields are only meaningful during the issue pulse
    assign mem_if.lsb_mem_ready = w_issue;
    assign mem_if.r_nw_in       = w_issue & r_store[w_head_next];
    assign mem_if.work_type     = w_issue ? op_work_type(r_op[w_head_next][1:0]) : WT_BYTE;
    assign mem_if.addr          = w_issue ? r_addr[w_head_next]  : '0;
    assign mem_if.data_in       = w_issue ? r_value[w_head_next] : '0;

    assign o_lsb_cdb_ready  = w_pop & ~r_store[r_head];
    assign o_lsb_cdb_rob_id = o_lsb_cdb_ready ? r_rob_id[r_head] : '0;
    assign o_lsb_cdb_value  = o_lsb_cdb_ready ? w_ext_value : '0;

endmodule

// File: tb/tb_lsb_queue_param.sv
// Directed bench for the load/store queue: a table of load-size vectors,
// then hand-written sequences for stores, fill/wrap, flush and kill.
module tb_lsb_queue_param;
    import lsb_queue_param_pkg::*;

    localparam int DEPTH = 8;
    localparam int ROB_W = 5;
    localparam int XLEN  = 32;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               i_clear;
    logic               i_ls_ready;
    logic               i_ls_store;
    logic [2:0]         i_ls_op;
    logic [ROB_W-1:0]   i_ls_rob_id;
    logic               o_ls_full;
    logic               i_lsb_rs_ready;
    logic [ROB_W-1:0]   i_lsb_rs_rob_id;
    logic [XLEN-1:0]    i_lsb_rs_st_value;
    logic [XLEN-1:0]    i_lsb_rs_ptr_value;
    logic               i_lsb_store_commit;
    logic [ROB_W-1:0]   i_lsb_store_commit_rob_id;
    logic               o_lsb_cdb_ready;
    logic [ROB_W-1:0]   o_lsb_cdb_rob_id;
    logic [XLEN-1:0]    o_lsb_cdb_value;

    lsb_queue_param_if #(.XLEN(XLEN)) mem_if ();

    lsb_queue_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .rdy_in                    (rdy_in),
        .i_clear                   (i_clear),
        .i_ls_ready                (i_ls_ready),
        .i_ls_store                (i_ls_store),
        .i_ls_op                   (i_ls_op),
        .i_ls_rob_id               (i_ls_rob_id),
        .o_ls_full                 (o_ls_full),
        .i_lsb_rs_ready            (i_lsb_rs_ready),
        .i_lsb_rs_rob_id           (i_lsb_rs_rob_id),
        .i_lsb_rs_st_value         (i_lsb_rs_st_value),
        .i_lsb_rs_ptr_value        (i_lsb_rs_ptr_value),
        .i_lsb_store_commit        (i_lsb_store_commit),
        .i_lsb_store_commit_rob_id (i_lsb_store_commit_rob_id),
        .mem_if                    (mem_if.master),
        .o_lsb_cdb_ready           (o_lsb_cdb_ready),
        .o_lsb_cdb_rob_id          (o_lsb_cdb_rob_id),
        .o_lsb_cdb_value           (o_lsb_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rob;
        logic [31:0] addr;
        logic [31:0] mem;
        logic [1:0]  wt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic alloc(input logic st, input logic [2:0] op, input logic [4:0] rob);
        i_ls_ready  = 1'b1;
        i_ls_store  = st;
        i_ls_op     = op;
        i_ls_rob_id = rob;
        step();
        i_ls_ready  = 1'b0;
    endtask

    task automatic operand(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] val);
        i_lsb_rs_ready     = 1'b1;
        i_lsb_rs_rob_id    = rob;
        i_lsb_rs_ptr_value = addr;
        i_lsb_rs_st_value  = val;
        step();
        i_lsb_rs_ready     = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rob);
        i_lsb_store_commit        = 1'b1;
        i_lsb_store_commit_rob_id = rob;
        step();
        i_lsb_store_commit        = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{F3_LW,  5'd3, 32'h100, 32'hDEADBEEF, WT_WORD, 32'hDEADBEEF};
        vecs[1] = '{F3_LB,  5'd4, 32'h104, 32'h00000080, WT_BYTE, 32'hFFFFFF80};
        vecs[2] = '{F3_LBU, 5'd5, 32'h108, 32'h00000080, WT_BYTE, 32'h00000080};
        vecs[3] = '{F3_LH,  5'd6, 32'h10C, 32'h00008001, WT_HALF, 32'hFFFF8001};
        vecs[4] = '{F3_LHU, 5'd7, 32'h110, 32'hFFFF8001, WT_HALF, 32'h00008001};
        vecs[5] = '{F3_LB,  5'd8, 32'h114, 32'h1234567F, WT_BYTE, 32'h0000007F};

        rst_in = 1'b1; rdy_in = 1'b1; i_clear = 1'b0;
        i_ls_ready = 1'b0; i_ls_store = 1'b0; i_ls_op = 3'd0; i_ls_rob_id = '0;
        i_lsb_rs_ready = 1'b0; i_lsb_rs_rob_id = '0; i_lsb_rs_st_value = '0; i_lsb_rs_ptr_value = '0;
        i_lsb_store_commit = 1'b0; i_lsb_store_commit_rob_id = '0;
        mem_if.mem_busy = 1'b0; mem_if.mem_done = 1'b0; mem_if.data_out = '0;

        // Reset state
        repeat (3) step();
        check("rst_full",      32'(o_ls_full), 0);
        check("rst_mem_ready", 32'(mem_if.lsb_mem_ready), 0);
        check("rst_cdb_ready", 32'(o_lsb_cdb_ready), 0);
        check("rst_addr",      mem_if.addr, 0);
        check("rst_cdb_value", o_lsb_cdb_value, 0);
        rst_in = 1'b0;
        step();

        // Load vectors: one request each, extended result on the CDB
        for (int v = 0; v < 6; v++) begin
            alloc(1'b0, vecs[v].op, vecs[v].rob);
            operand(vecs[v].rob, vecs[v].addr, 32'h0);
            check("ld_req",      32'(mem_if.lsb_mem_ready), 1);
            check("ld_addr",     mem_if.addr, vecs[v].addr);
            check("ld_r_nw",     32'(mem_if.r_nw_in), 0);
            check("ld_work",     32'(mem_if.work_type), 32'(vecs[v].wt));
            step();
            check("ld_single_req", 32'(mem_if.lsb_mem_ready), 0);
            mem_if.mem_done = 1'b1;
            mem_if.data_out = vecs[v].mem;
            #1;
            check("ld_cdb_ready", 32'(o_lsb_cdb_ready), 1);
            check("ld_cdb_rob",   32'(o_lsb_cdb_rob_id), 32'(vecs[v].rob));
            check("ld_cdb_value", o_lsb_cdb_value, vecs[v].exp);
            $display("load vec %0d op=%0d rob=%0d mem=%08h cdb=%08h", v, vecs[v].op, vecs[v].rob,
                     vecs[v].mem, o_lsb_cdb_value);
            step();
            mem_if.mem_done = 1'b0;
        end

        // SH waits for commit, then issues sized data
        alloc(1'b1, F3_SH, 5'd9);
        operand(5'd9, 32'h200, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            check("sh_no_req_before_commit", 32'(mem_if.lsb_mem_ready), 0);
            step();
        end
        commit(5'd9);
        check("sh_req",   32'(mem_if.lsb_mem_ready), 1);
        check("sh_data",  mem_if.data_in, 32'h5678);
        check("sh_work",  32'(mem_if.work_type), 32'(WT_HALF));
        check("sh_r_nw",  32'(mem_if.r_nw_in), 1);
        check("sh_addr",  mem_if.addr, 32'h200);
        step();
        mem_if.mem_done = 1'b1;
        #1;
        check("sh_no_cdb", 32'(o_lsb_cdb_ready), 0);
        $display("store SH rob=9 data_in issued, completed");
        step();
        mem_if.mem_done = 1'b0;

        // SB commit before operands is latched
        alloc(1'b1, F3_SB, 5'd10);
        commit(5'd10);
        check("sb_no_req_early", 32'(mem_if.lsb_mem_ready), 0);
        operand(5'd10, 32'h208, 32'hAABBCCDD);
        check("sb_req",  32'(mem_if.lsb_mem_ready), 1);
        check("sb_data", mem_if.data_in, 32'hDD);
        check("sb_work", 32'(mem_if.work_type), 32'(WT_BYTE));
        step();
        mem_if.mem_done = 1'b1;
        #1;
        check("sb_no_cdb", 32'(o_lsb_cdb_ready), 0);
        $display("store SB rob=10 early commit, completed");
        step();
        mem_if.mem_done = 1'b0;

        // Stall, then flush with an issued load: its completion is dropped
        alloc(1'b0, F3_LW, 5'd12);
        operand(5'd12, 32'h500, 32'h0);
        rdy_in = 1'b0;
        #1;
        check("stall_no_req", 32'(mem_if.lsb_mem_ready), 0);
        step(); step();
        rdy_in = 1'b1;
        #1;
        check("stall_release_req",  32'(mem_if.lsb_mem_ready), 1);
        check("stall_release_addr", mem_if.addr, 32'h500);
        step();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        alloc(1'b0, F3_LW, 5'd13);
        operand(5'd13, 32'h504, 32'h0);
        check("kill_blocks_issue", 32'(mem_if.lsb_mem_ready), 0);
        mem_if.mem_done = 1'b1;
        mem_if.data_out = 32'h00000777;
        #1;
        check("kill_no_cdb",      32'(o_lsb_cdb_ready), 0);
        check("kill_next_issue",  32'(mem_if.lsb_mem_ready), 1);
        check("kill_next_addr",   mem_if.addr, 32'h504);
        step();
        mem_if.data_out = 32'h11223344;
        #1;
        check("after_kill_cdb",   32'(o_lsb_cdb_ready), 1);
        check("after_kill_rob",   32'(o_lsb_cdb_rob_id), 13);
        check("after_kill_value", o_lsb_cdb_value, 32'h11223344);
        $display("flush with issued load rob=12 killed, rob=13 cdb=%08h", o_lsb_cdb_value);
        step();
        mem_if.mem_done = 1'b0;

        // Fill to DEPTH (head no longer at slot 0, so the tail wraps)
        mem_if.mem_busy = 1'b1;
        for (int r = 16; r < 24; r++) begin
            check("fill_not_full", 32'(o_ls_full), 0);
            alloc(1'b0, F3_LW, 5'(r));
        end
        check("fill_full", 32'(o_ls_full), 1);
        for (int r = 16; r < 24; r++) operand(5'(r), 32'h300 + 32'(4 * (r - 16)), 32'h0);
        mem_if.mem_busy = 1'b0;
        #1;
        check("fill_first_req", mem_if.addr, 32'h300);
        step();
        mem_if.mem_done = 1'b1;
        mem_if.data_out = 32'h1000 + 32'd16;
        #1;
        check("pop16_rob",       32'(o_lsb_cdb_rob_id), 16);
        check("zero_bubble_req", 32'(mem_if.lsb_mem_ready), 1);
        check("zero_bubble_addr", mem_if.addr, 32'h304);
        step();
        check("after_pop_not_full", 32'(o_ls_full), 0);
        // Pop and alloc in the same cycle: occupancy unchanged
        mem_if.data_out = 32'h1000 + 32'd17;
        i_ls_ready = 1'b1; i_ls_store = 1'b0; i_ls_op = F3_LW; i_ls_rob_id = 5'd24;
        #1;
        check("pop17_rob", 32'(o_lsb_cdb_rob_id), 17);
        step();
        i_ls_ready = 1'b0;
        mem_if.mem_done = 1'b0;
        check("pop_alloc_not_full", 32'(o_ls_full), 0);
        alloc(1'b0, F3_LW, 5'd25);
        check("refill_full", 32'(o_ls_full), 1);
        operand(5'd24, 32'h320, 32'h0);
        operand(5'd25, 32'h324, 32'h0);
        for (int r = 18; r <= 25; r++) begin
            mem_if.mem_done = 1'b1;
            mem_if.data_out = 32'h1000 + 32'(r);
            #1;
            check("drain_cdb_ready", 32'(o_lsb_cdb_ready), 1);
            check("drain_cdb_rob",   32'(o_lsb_cdb_rob_id), 32'(r));
            check("drain_cdb_value", o_lsb_cdb_value, 32'h1000 + 32'(r));
            if (r < 25) check("drain_next_addr", mem_if.addr, 32'h300 + 32'(4 * (r + 1 - 16)));
            $display("drain pop rob=%0d value=%08h", o_lsb_cdb_rob_id, o_lsb_cdb_value);
            step();
            if (r == 18) check("drain_not_full", 32'(o_ls_full), 0);
        end
        mem_if.mem_done = 1'b0;
        #1;
        check("drain_idle", 32'(mem_if.lsb_mem_ready), 0);

        // Flush keeps only the committed store at head
        mem_if.mem_busy = 1'b1;
        alloc(1'b1, F3_SW, 5'd1);
        operand(5'd1, 32'h400, 32'hCAFEF00D);
        commit(5'd1);
        for (int r = 2; r < 5; r++) begin
            alloc(1'b0, F3_LW, 5'(r));
            operand(5'(r), 32'h404 + 32'(4 * (r - 2)), 32'h0);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        for (int r = 5; r < 11; r++) alloc(1'b0, F3_LW, 5'(r));
        check("flush_count1_not_full", 32'(o_ls_full), 0);
        alloc(1'b0, F3_LW, 5'd11);
        check("flush_count1_full", 32'(o_ls_full), 1);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("flush2_not_full", 32'(o_ls_full), 0);
        mem_if.mem_busy = 1'b0;
        #1;
        check("flush_st_req",  32'(mem_if.lsb_mem_ready), 1);
        check("flush_st_r_nw", 32'(mem_if.r_nw_in), 1);
        check("flush_st_addr", mem_if.addr, 32'h400);
        check("flush_st_data", mem_if.data_in, 32'hCAFEF00D);
        step();
        mem_if.mem_done = 1'b1;
        #1;
        check("flush_st_no_cdb",   32'(o_lsb_cdb_ready), 0);
        check("flush_no_more_req", 32'(mem_if.lsb_mem_ready), 0);
        $display("flush kept SW rob=1, loads discarded");
        step();
        mem_if.mem_done = 1'b0;
        repeat (3) begin
            check("flush_quiet", 32'(mem_if.lsb_mem_ready), 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
